// File: rtl/gsm_burst_sequencer_if.sv
// Symbol/payload bus between the burst sequencer, its payload source and the GMSK modulator.
// master drives the requests, strobe and payload; slave is the sequencer.
interface gsm_burst_sequencer_if;
  logic start_i;
  logic data_i;
  logic data_valid_i;
  logic data_ready_o;
  logic symbol_strobe_i;
  logic current_symbol_o;
  logic burst_active_o;
  logic burst_done_o;
  logic underrun_o;

  modport master (
    output start_i, data_i, data_valid_i, symbol_strobe_i,
    input  data_ready_o, current_symbol_o, burst_active_o, burst_done_o, underrun_o
  );

  modport slave (
    input  start_i, data_i, data_valid_i, symbol_strobe_i,
    output data_ready_o, current_symbol_o, burst_active_o, burst_done_o, underrun_o
  );
endinterface

// File: rtl/gsm_burst_sequencer.sv
// GSM normal-burst framer: lead tail, payload, trail tail, guard, differentially
// encoded and paced by the modulator symbol strobe.
module gsm_burst_sequencer #(
  parameter int PAYLOAD_BITS = 142,
  parameter int TAIL_BITS    = 3,   // must be >= 2: the entry strobe emits the first lead bit
  parameter int GUARD_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  gsm_burst_sequencer_if.slave  bus
);

  localparam int MAX_PT   = (PAYLOAD_BITS > TAIL_BITS) ? PAYLOAD_BITS : TAIL_BITS;
  localparam int MAX_BITS = (MAX_PT > GUARD_BITS) ? MAX_PT : GUARD_BITS;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam int FW       = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] LEAD_LAST  = CW'(TAIL_BITS - 2);
  localparam logic [CW-1:0] PAY_LAST   = CW'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0] TRAIL_LAST = CW'(TAIL_BITS - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_BITS - 1);
  localparam logic [FW-1:0] PAY_TOTAL  = FW'(PAYLOAD_BITS);

  typedef enum logic [2:0] {IDLE, LEAD, PAYLOAD, TRAIL, GUARD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] fetched;
  logic          buf_full, buf_bit;
  logic          start_pending;
  logic          prev_b;
  logic          sym_q, done_q, under_q;
  logic          sym_b, done_nx, under_nx, consume;
  logic          ready, xfer, lead_entry, trail_entry;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sym_b    = 1'b1;
    done_nx  = 1'b0;
    under_nx = 1'b0;
    consume  = 1'b0;
    if (bus.symbol_strobe_i) begin
      cnt_nx = cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt_nx = '0;
          if (start_pending || bus.start_i) begin
            sym_b    = 1'b0;
            state_nx = LEAD;
          end
        end
        LEAD: begin
          sym_b = 1'b0;
          if (cnt == LEAD_LAST) begin
            state_nx = PAYLOAD;
            cnt_nx   = '0;
          end
        end
        PAYLOAD: begin
          // an empty buffer substitutes a zero and flags it, but the burst keeps its timing
          sym_b    = buf_full & buf_bit;
          consume  = buf_full;
          under_nx = ~buf_full;
          if (cnt == PAY_LAST) begin
            state_nx = TRAIL;
            cnt_nx   = '0;
          end
        end
        TRAIL: begin
          sym_b = 1'b0;
          if (cnt == TRAIL_LAST) begin
            state_nx = GUARD;
            cnt_nx   = '0;
          end
        end
        GUARD: begin
          sym_b = 1'b1;
          if (cnt == GUARD_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign ready       = ~buf_full && (state == LEAD || state == PAYLOAD) && (fetched < PAY_TOTAL);
  assign xfer        = bus.data_valid_i & ready;
  assign lead_entry  = (state == IDLE) && (state_nx == LEAD);
  assign trail_entry = (state == PAYLOAD) && (state_nx == TRAIL);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      fetched       <= '0;
      buf_full      <= 1'b0;
      buf_bit       <= 1'b0;
      start_pending <= 1'b0;
      prev_b        <= 1'b1;
      sym_q         <= 1'b0;
      done_q        <= 1'b0;
      under_q       <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      done_q  <= done_nx;
      under_q <= under_nx;
      if (bus.symbol_strobe_i) begin
        sym_q  <= sym_b ^ prev_b;
        prev_b <= sym_b;
      end
      if (lead_entry)
        start_pending <= 1'b0;
      else if (state == IDLE && bus.start_i)
        start_pending <= 1'b1;
      if (lead_entry)
        fetched <= '0;
      else if (xfer)
        fetched <= fetched + FW'(1);
      // consume before accept; anything still buffered at payload end is stale
      if (trail_entry)
        buf_full <= 1'b0;
      else
        buf_full <= (buf_full & ~consume) | xfer;
      if (xfer)
        buf_bit <= bus.data_i;
    end
  end

  assign bus.data_ready_o     = ready;
  assign bus.current_symbol_o = sym_q;
  assign bus.burst_active_o   = (state != IDLE);
  assign bus.burst_done_o     = done_q;
  assign bus.underrun_o       = under_q;

endmodule

// File: tb/tb_gsm_burst_sequencer.sv
// Bench for gsm_burst_sequencer: table of burst scenarios with a per-strobe scoreboard,
// plus hand sequences for reset, mid-burst abort and start during guard.
module tb_gsm_burst_sequencer;
  localparam int PB   = 142;
  localparam int TBB  = 3;
  localparam int GB   = 8;
  localparam int NSYM = PB + 2*TBB + GB;
  localparam int GAP  = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  gsm_burst_sequencer_if ifc();

  gsm_burst_sequencer #(.PAYLOAD_BITS(PB), .TAIL_BITS(TBB), .GUARD_BITS(GB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pattern;          // 0 zeros, 1 alternating 1/0, 2 random
    int hold_lo;          // payload symbols hold_lo..hold_hi withheld (0 = none)
    int hold_hi;
    bit start_on_strobe;
    int exp_und;
    int exp_hs;
    int exp_ones;         // -1 = not checked
  } vec_t;

  typedef struct {
    bit d;
    bit active;
    bit done;
    bit und;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[4];
  vec_t cv;
  bit   pay[PB];
  bit   prev_m;
  int   compared = 0, mismatched = 0;
  int   hs, und_cnt, done_cnt, ones_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_hold(input int s);
    int j;
    j = s - TBB;
    return (cv.hold_lo > 0) && (s > TBB) && (s <= TBB + PB) && (j >= cv.hold_lo) && (j <= cv.hold_hi);
  endfunction

  function automatic bit exp_b(input int s);
    int j, k;
    if (s <= TBB) return 1'b0;
    if (s <= TBB + PB) begin
      j = s - TBB;
      if (in_hold(s)) return 1'b0;
      k = j - 1;
      if (cv.hold_lo > 0 && j > cv.hold_hi) k = j - 1 - (cv.hold_hi - cv.hold_lo + 1);
      return pay[k];
    end
    if (s <= 2*TBB + PB) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle(input bit strobe, input bit start);
    bit   xfer;
    exp_t e;
    ifc.symbol_strobe_i = strobe;
    ifc.start_i = start;
    @(negedge clock);
    xfer = ifc.data_valid_i & ifc.data_ready_o;
    @(posedge clock);
    #1;
    ifc.symbol_strobe_i = 1'b0;
    ifc.start_i = 1'b0;
    if (xfer) hs++;
    ifc.data_i = (hs < PB) ? pay[hs] : 1'b0;
    und_cnt  += int'(ifc.underrun_o);
    done_cnt += int'(ifc.burst_done_o);
    if (strobe) begin
      if (sbq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = sbq.pop_front();
        ones_cnt += int'(ifc.current_symbol_o);
        chk("symbol_d", ifc.current_symbol_o, e.d);
        chk("burst_active", ifc.burst_active_o, e.active);
        chk("burst_done", ifc.burst_done_o, e.done);
        chk("underrun", ifc.underrun_o, e.und);
      end
    end
  endtask

  // s = symbol index within the burst (1..NSYM), 0 for an idle strobe
  task automatic strobe_sym(input int s, input bit start);
    exp_t e;
    bit   b;
    b = (s == 0) ? 1'b1 : exp_b(s);
    e.d      = b ^ prev_m;
    prev_m   = b;
    e.active = (s >= 1) && (s < NSYM);
    e.done   = (s == NSYM);
    e.und    = (s != 0) && in_hold(s);
    sbq.push_back(e);
    cycle(1'b1, start);
  endtask

  task automatic gap_cycles(input bit start_first);
    for (int g = 0; g < GAP; g++) cycle(1'b0, start_first && (g == 0));
  endtask

  task automatic run_burst(input vec_t v, input int stop_at, input int guard_start_at);
    int pe;
    cv = v;
    for (int i = 0; i < PB; i++)
      case (v.pattern)
        0:       pay[i] = 1'b0;
        1:       pay[i] = (i % 2 == 0);
        default: pay[i] = 1'($urandom_range(0, 1));
      endcase
    hs = 0; und_cnt = 0; done_cnt = 0; ones_cnt = 0;
    ifc.data_i = pay[0];
    ifc.data_valid_i = 1'b1;
    strobe_sym(0, 1'b0);
    gap_cycles(1'b0);
    if (!v.start_on_strobe) begin
      cycle(1'b0, 1'b1);
      gap_cycles(1'b0);
    end
    for (int s = 1; s <= NSYM; s++) begin
      if (s > 1) gap_cycles(s == guard_start_at);
      strobe_sym(s, v.start_on_strobe && (s == 1));
      pe = s - TBB;
      ifc.data_valid_i = !((v.hold_lo > 0) && (pe >= v.hold_lo - 1) && (pe < v.hold_hi));
      if (s == stop_at) return;
    end
    ifc.data_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gap_cycles(1'b0);
      strobe_sym(0, 1'b0);
    end
    chk("underrun_count", und_cnt, v.exp_und);
    chk("handshake_count", hs, v.exp_hs);
    chk("done_count", done_cnt, 1);
    if (v.exp_ones >= 0) chk("d_ones_count", ones_cnt, v.exp_ones);
  endtask

  initial begin
    vt[0] = '{0, 0,  0,  1'b0, 0, PB,     2};
    vt[1] = '{1, 0,  0,  1'b0, 0, PB,     PB + 2};
    vt[2] = '{2, 10, 11, 1'b0, 2, PB - 2, -1};
    vt[3] = '{1, 0,  0,  1'b1, 0, PB,     PB + 2};

    ifc.start_i = 1'b0;
    ifc.data_i = 1'b0;
    ifc.data_valid_i = 1'b1;
    ifc.symbol_strobe_i = 1'b0;
    hs = 0; und_cnt = 0; done_cnt = 0; ones_cnt = 0;
    prev_m = 1'b1;

    reset_n = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("rst_symbol", ifc.current_symbol_o, 1'b0);
    chk("rst_ready", ifc.data_ready_o, 1'b0);
    chk("rst_active", ifc.burst_active_o, 1'b0);
    chk("rst_done", ifc.burst_done_o, 1'b0);
    chk("rst_underrun", ifc.underrun_o, 1'b0);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0);

    for (int i = 0; i < 4; i++) run_burst(vt[i], 0, 0);

    // start during guard must be dropped: the trailing idle strobes keep d=0
    run_burst(vt[0], 0, TBB + PB + TBB + 3);

    // abort after payload symbol 50
    run_burst(vt[1], TBB + 50, 0);
    reset_n = 1'b0;
    cycle(1'b0, 1'b0);
    chk("abort_symbol", ifc.current_symbol_o, 1'b0);
    chk("abort_ready", ifc.data_ready_o, 1'b0);
    chk("abort_active", ifc.burst_active_o, 1'b0);
    chk("abort_done", ifc.burst_done_o, 1'b0);
    chk("abort_underrun", ifc.underrun_o, 1'b0);
    reset_n = 1'b1;
    prev_m = 1'b1;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_ready_idle", ifc.data_ready_o, 1'b0);
    run_burst(vt[0], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
